// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with valid/ready on both sides.
// S1 holds the raw codeword plus syndrome; S2 holds the corrected result and drives the outputs.
module hamming_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       code_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic             err_corr,
    output logic [2:0]       err_pos,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
        logic [2:0] pos;
    } dec_t;

    logic [2:1]       vld_pipe;
    logic [6:0]       s1_code;
    logic [2:0]       s1_syn;
    logic [2:0]       syn_in;
    logic [6:0]       fixed;
    dec_t             s2_d, s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_fire, s2_adv, s1_mv;

    // Each syndrome bit covers the positions whose index has that bit set.
    assign syn_in = {^(code_in & 7'b1111000), ^(code_in & 7'b1100110), ^(code_in & 7'b1010101)};

    assign s2_adv   = !vld_pipe[2] | out_ready;
    assign s1_mv    = vld_pipe[1] & s2_adv;
    assign in_ready = !vld_pipe[1] | s2_adv;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        s2_d  = '0;
        fixed = s1_code;
        if (s1_syn != 3'd0) begin
            s2_d.err = 1'b1;
            s2_d.pos = s1_syn - 3'd1;
            fixed    = s1_code ^ (7'd1 << s2_d.pos);
        end
        s2_d.syn  = s1_syn;
        s2_d.data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s2_q     <= '0;
        end else begin
            if (in_fire) begin
                vld_pipe[1] <= 1'b1;
                s1_code     <= code_in;
                s1_syn      <= syn_in;
            end else if (s1_mv) begin
                vld_pipe[1] <= 1'b0;
            end
            if (s1_mv) begin
                vld_pipe[2] <= 1'b1;
                s2_q        <= s2_d;
            end else if (out_ready) begin
                vld_pipe[2] <= 1'b0;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_count)
            cnt_q <= '0;
        else if (s1_mv && s2_d.err && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign out_valid = vld_pipe[2];
    assign data_out  = s2_q.data;
    assign syndrome  = s2_q.syn;
    assign err_corr  = s2_q.err;
    assign err_pos   = s2_q.pos;
    assign err_count = cnt_q;

endmodule
